fifo_stream_drain: RTL
======================

// Module: fifo_stream_drain
// PURPOSE
//  Read-side drain stage for one port of the async (bidir) FIFO, FALLTHROUGH="TRUE" mode.
//  Pops words via rinc/empty/rdata and parses length-prefixed packets.
//  Emits the payload on a valid/ready stream with tlast, buffered by a 2-entry skid buffer.
//  Sits in the consuming clock domain directly downstream of the FIFO; that port's dir is held 0.
// PARAMETERS
//  DSIZE     8   FIFO word width = stream data width = header width
//  CNT_W     16  width of the delivered-packet counter
// PORTS
//  clk          in   1      consuming-domain clock (same clock as the FIFO port)
//  rst_n        in   1      asynchronous active-low reset
//  enable       in   1      1: drain allowed; 0: stop popping (buffered words still drain)
//  fifo_empty   in   1      FIFO port empty flag
//  fifo_rdata   in   DSIZE  FIFO head word, valid whenever fifo_empty=0 (fall-through)
//  fifo_rinc    out  1      pop strobe; one word removed per cycle it is high
//  m_tvalid     out  1      stream word valid
//  m_tready     in   1      downstream accepts
//  m_tdata      out  DSIZE  payload word
//  m_tlast      out  1      final payload word of a packet
//  in_packet    out  1      1 while header consumed but last payload word not yet popped
//  pkt_cnt      out  CNT_W  packets fully accepted downstream, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async): fifo_rinc=0, m_tvalid=0, m_tdata=0, m_tlast=0, in_packet=0, pkt_cnt=0.
//    Reset clears the skid buffer and returns the FSM to HDR.
//  Packet format: header word H, then H+1 payload words (1..2^DSIZE). H is not forwarded.
//  Pop rule (combinational):
//    fifo_rinc = enable & !fifo_empty & space.
//    space = (occupancy<2), or occupancy==2 with a word leaving this cycle.
//    In state HDR, space is always 1, since the header does not enter the buffer.
//    fifo_rinc is never high while fifo_empty=1.
//  FSM HDR: on a pop, latch rem<=fifo_rdata, go to PAYLOAD, in_packet<=1.
//  FSM PAYLOAD: on a pop, write {fifo_rdata, last=(rem==0)} into the skid buffer.
//    Then rem<=rem-1. If rem==0, go to HDR and set in_packet<=0.
//  Skid buffer: 2 entries, FIFO order; m_tdata/m_tlast/m_tvalid come from entry 0 registers.
//    A word popped in cycle N is presented (m_tvalid=1) at cycle N+1 when the buffer was empty.
//    Sustained throughput is 1 word/clk, with m_tready=1 and a non-empty FIFO.
//    Each packet costs one extra pop cycle for its header.
//  Handshake:
//    Transfer occurs when m_tvalid & m_tready.
//    While m_tvalid=1 & m_tready=0, m_tdata/m_tlast are held stable.
//    m_tvalid does not drop without a transfer.
//    Simultaneous push and transfer keeps occupancy unchanged; no bubble is inserted.
//  pkt_cnt increments on a transfer with m_tlast=1 (after downstream acceptance), mod 2^CNT_W.
//  fifo_empty mid-packet: popping pauses and FSM/rem are held; the packet resumes when data returns.
//  enable=0 mid-packet: same as empty; the already-buffered words are still delivered.
//  Header with fifo_empty toggling: nothing is consumed until the header is popped.
//  Reset mid-packet: the partial packet is discarded from this block's state.
//    FIFO contents are not touched; resynchronising framing is the system's responsibility.
// TESTING
//  1 Reset with fifo_empty=0, enable=1 -> all outputs 0 during reset; first pop after release.
//  2 FIFO holds 02,A1,A2,A3; m_tready=1 -> 4 pops.
//    Beats are A1,A2,A3 on consecutive cycles; tlast only on A3; pkt_cnt=1.
//  3 Same packet, m_tready=0 for 5 cycles on A2 -> A2 held stable, occupancy<=2.
//    fifo_rinc stops once the buffer is full; no data is lost or duplicated.
//  4 Header FF + 256 words, then header 00 + B0, back-to-back, m_tready=1.
//    257 beats, tlast on word 256 and on B0; one-cycle header gap only; pkt_cnt=2.
//  5 fifo_empty pulses mid-payload and enable=0 for 3 cycles.
//    No rinc while empty or disabled; framing intact; tlast correct.
//  6 Assert rst_n=0 after 2 of 4 payload words -> outputs reset, in_packet=0, pkt_cnt=0.
//    Next word popped is treated as a header.

Source files
------------

// File: rtl/fifo_stream_drain.sv
// Read-side drain for a fall-through FIFO port: strips the length header of each
// packet and forwards the payload on a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_drain #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             fifo_rinc,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tlast,
  output logic             in_packet,
  output logic [CNT_W-1:0] pkt_cnt
);

  typedef enum logic {HDR, PAYLOAD} state_t;

  state_t             state_q, state_d;
  logic [DSIZE-1:0]   rem_q, rem_d;
  logic               v0_q, v0_d, v1_q, v1_d;
  logic [DSIZE-1:0]   d0_q, d0_d, d1_q, d1_d;
  logic               l0_q, l0_d, l1_q, l1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic xfer, space, pop, push, push_last;

  assign xfer      = v0_q & m_tready;
  // The header never occupies a buffer slot, so it can be popped even when full.
  assign space     = (state_q == HDR) | ~v1_q | xfer;
  assign pop       = rst_n & enable & ~fifo_empty & space;
  assign push      = pop & (state_q == PAYLOAD);
  assign push_last = (rem_q == '0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    l0_d    = l0_q;
    l1_d    = l1_q;
    cnt_d   = cnt_q;

    if (pop) begin
      case (state_q)
        HDR: begin
          rem_d   = fifo_rdata;
          state_d = PAYLOAD;
        end
        PAYLOAD: begin
          rem_d = rem_q - 1'b1;
          if (push_last) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end

    if (xfer) begin
      if (v1_q) begin
        d0_d = d1_q;
        l0_d = l1_q;
        v0_d = 1'b1;
        v1_d = push;
        if (push) begin
          d1_d = fifo_rdata;
          l1_d = push_last;
        end
      end else begin
        v0_d = push;
        if (push) begin
          d0_d = fifo_rdata;
          l0_d = push_last;
        end
      end
    end else if (push) begin
      if (v0_q) begin
        v1_d = 1'b1;
        d1_d = fifo_rdata;
        l1_d = push_last;
      end else begin
        v0_d = 1'b1;
        d0_d = fifo_rdata;
        l0_d = push_last;
      end
    end

    if (xfer && l0_q) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
      rem_q   <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      l0_q    <= 1'b0;
      l1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      l0_q    <= l0_d;
      l1_q    <= l1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_rinc = pop;
  assign m_tvalid  = v0_q;
  assign m_tdata   = d0_q;
  assign m_tlast   = l0_q;
  assign in_packet = (state_q == PAYLOAD);
  assign pkt_cnt   = cnt_q;

endmodule
